// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Oversampling 8N1-style UART receiver feeding a first-word-fall-through
// receive FIFO. This is the receive stage in front of the UART register block.
//
// The serial input is synchronised, sampled 16x per bit, and checked for a
// valid start and stop bit. Each good byte is pushed into the FIFO. The
// register block reads the head byte and pops it with a one-cycle handshake.
//
// Parameters
//   DATA_WIDTH  data bits per frame (>= 2)
//   CLK_FREQ    clk frequency in Hz
//   UART_SPEED  baud rate
//   FIFO_DEPTH  FIFO entries, a power of 2 and >= 2
//
// Ports
//   clk        clock
//   arstn      asynchronous active-low reset
//   rx         serial input, asynchronous to clk, idles high
//   pop        consume the head entry (ignored while empty)
//   clr_err    clear the sticky frame_err / overrun flags
//   rdata      FIFO head byte, valid while !empty
//   empty      FIFO holds no entries
//   full       FIFO holds FIFO_DEPTH entries
//   count      number of entries held
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a good byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_SPEED = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic                          rx,
    input  logic                          pop,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DIV_RAW = CLK_FREQ / (UART_SPEED * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    // Reset to 1 so that coming out of reset does not look like a start bit.
    logic [1:0] rx_sync;
    logic       rx_s;

    // NOTE: every sequential block uses non-blocking assignments so that all
    // flops sample their inputs from the same edge, independent of the order
    // in which the simulator evaluates the always_ff blocks.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];

    // -------------------------------------------------------------------------
    // Oversample tick generator
    // -------------------------------------------------------------------------
    // The divider restarts when a start edge is seen, so the 16x sample grid
    // is phase-aligned to the falling edge of the start bit.
    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               start_det;

    assign start_det = (state == S_IDLE) && !rx_s;
    assign tick      = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            div_cnt <= '0;
        end else if (start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    // START samples at oversample count 7 (middle of the start bit); after
    // that the counter restarts at 0, so every later sample taken at count 15
    // lands 16 ticks further on, in the middle of each data and stop bit.
    logic [3:0]             sample_cnt;
    logic [BIT_W-1:0]       bit_idx;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic                   push_req;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            push_req   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push_req <= 1'b0;

            // Clear first so that a framing error in the same cycle wins.
            if (clr_err) begin
                frame_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state      <= S_START;
                        sample_cnt <= '0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (sample_cnt == 4'd7) begin
                            if (rx_s) begin
                                // Line went back high before mid-bit: glitch.
                                state <= S_IDLE;
                            end else begin
                                state      <= S_DATA;
                                sample_cnt <= '0;
                                bit_idx    <= '0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        // 4-bit counter wraps 15 -> 0 by itself.
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == 4'd15) begin
                            // LSB first: new bits enter at the top and shift down.
                            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                            if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                                state <= S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 4'd1;
                        if (sample_cnt == 4'd15) begin
                            if (rx_s) begin
                                // shift_reg stays stable until the next frame's
                                // first data bit, so the FIFO writes it directly.
                                push_req <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_WAIT_HIGH;
                            end
                        end
                    end
                end

                S_WAIT_HIGH: begin
                    // A held-low line (break) reports a single framing error
                    // and is not re-interpreted as a stream of start bits.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count_q;
    logic                   do_push;
    logic                   do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign count  = count_q;
    assign rdata  = mem[rd_ptr];

    // A pop on an empty FIFO is ignored, even when a push lands that cycle.
    // A push into a full FIFO is accepted only when a pop frees a slot in the
    // same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push_req && (!full || pop);

    // NOTE: the storage array has no reset; only pointers and count are
    // reset, which is enough to make the contents unobservable, and it keeps
    // the array mappable onto plain RAM or reset-less flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            overrun <= 1'b0;
        end else begin
            // Pointers are exactly log2(depth) bits wide and wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end

            if (clr_err) begin
                overrun <= 1'b0;
            end
            if (push_req && full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
